// File: rtl/axi_pkg.sv
// Shared types for the AXI4 mesh memory endpoint: burst encodings, response codes
// and the endpoint controller state encoding.
package axi_pkg;

    typedef enum logic [1:0] {
        FIXED = 2'b00,
        INCR  = 2'b01,
        WRAP  = 2'b10
    } burst_t;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } resp_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        W_DATA  = 3'd1,
        W_RESP  = 3'd2,
        R_FETCH = 3'd3,
        R_DATA  = 3'd4
    } state_t;

    // FIXED holds the beat address; INCR, WRAP and the reserved code all increment.
    function automatic logic is_fixed(input logic [1:0] burst);
        return (burst == FIXED);
    endfunction

endpackage

// File: rtl/axi_if.sv
// AXI4 channel bundle (AW, W, B, AR, R) between a mesh port and a memory endpoint.
interface axi_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 12,
    parameter int ID_W_WIDTH = 5,
    parameter int ID_R_WIDTH = 5
) ();
    logic [ID_W_WIDTH-1:0]   awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awvalid;
    logic                    awready;

    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;

    logic [ID_W_WIDTH-1:0]   bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    logic [ID_R_WIDTH-1:0]   arid;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arvalid;
    logic                    arready;

    logic [ID_R_WIDTH-1:0]   rid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
        output wdata, wstrb, wlast, wvalid, input wready,
        input  bid, bresp, bvalid, output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
        input  rid, rdata, rresp, rlast, rvalid, output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
        input  wdata, wstrb, wlast, wvalid, output wready,
        output bid, bresp, bvalid, input bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid, output arready,
        output rid, rdata, rresp, rlast, rvalid, input rready
    );

endinterface

// File: rtl/sp_ram_be.sv
// Single-port RAM with per-byte write enables and a registered read port.
// Array contents are deliberately not reset; only the read register is.
module sp_ram_be #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4096
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     we,
    input  logic [DATA_WIDTH/8-1:0]  be,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [DATA_WIDTH-1:0]    wdata,
    output logic [DATA_WIDTH-1:0]    rdata
);
    localparam int STRB_W = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_r;

    // Byte-enabled write into the storage array.
    always_ff @(posedge clk) begin
        if (en && we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (be[b]) begin
                    mem_r[addr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    // Read register: loads only on a read so the value stays put while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_r <= {DATA_WIDTH{1'b0}};
        end else if (en && !we) begin
            rdata_r <= mem_r[addr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/axi_mesh_mem_slave.sv
// Per-node AXI4 memory endpoint: serves one read or write burst at a time from a
// single-port byte-enabled RAM, round-robin arbitrating AW against AR.
module axi_mesh_mem_slave
    import axi_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 12,
    parameter int ID_W_WIDTH = 5,
    parameter int ID_R_WIDTH = 5
) (
    input logic   clk,
    input logic   rst,
    axi_if.slave  axi_s
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int IDX_W  = ADDR_WIDTH - OFF_W;
    localparam int DEPTH  = 1 << IDX_W;

    state_t                 state_r, state_s;
    logic                   prio_write_r;
    logic [IDX_W-1:0]       addr_r, addr_next_s;
    logic [7:0]             len_r, cnt_r;
    logic                   fixed_r, err_r;
    logic [ID_W_WIDTH-1:0]  wid_r;
    logic [ID_R_WIDTH-1:0]  rid_r;
    logic                   bvalid_r, rvalid_r, rlast_r;
    resp_t                  bresp_r;

    logic grant_w_s, grant_r_s, aw_hs_s, ar_hs_s, w_hs_s;
    logic last_beat_s, wlast_bad_s;
    logic awready_s, arready_s, wready_s;
    logic ram_en_s, ram_we_s;
    logic [DATA_WIDTH-1:0] ram_rdata_s;
    logic unused_s;

    assign grant_w_s   = axi_s.awvalid && (!axi_s.arvalid || prio_write_r);
    assign grant_r_s   = axi_s.arvalid && !grant_w_s;
    assign aw_hs_s     = (state_r == IDLE) && grant_w_s;
    assign ar_hs_s     = (state_r == IDLE) && grant_r_s;
    assign w_hs_s      = (state_r == W_DATA) && axi_s.wvalid;
    assign last_beat_s = (cnt_r == len_r);
    assign wlast_bad_s = (axi_s.wlast != last_beat_s);
    assign addr_next_s = fixed_r ? addr_r : (addr_r + {{(IDX_W-1){1'b0}}, 1'b1});

    // Controller state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode plus ready strobes and RAM port controls.
    always_comb begin
        state_s   = state_r;
        awready_s = 1'b0;
        arready_s = 1'b0;
        wready_s  = 1'b0;
        ram_en_s  = 1'b0;
        ram_we_s  = 1'b0;
        case (state_r)
            IDLE: begin
                awready_s = grant_w_s;
                arready_s = grant_r_s;
                if (grant_w_s) begin
                    state_s = W_DATA;
                end else if (grant_r_s) begin
                    state_s = R_FETCH;
                end else begin
                    state_s = IDLE;
                end
            end
            W_DATA: begin
                wready_s = 1'b1;
                if (axi_s.wvalid) begin
                    ram_en_s = 1'b1;
                    ram_we_s = 1'b1;
                    state_s  = last_beat_s ? W_RESP : W_DATA;
                end else begin
                    state_s = W_DATA;
                end
            end
            W_RESP: begin
                if (axi_s.bready) begin
                    state_s = IDLE;
                end else begin
                    state_s = W_RESP;
                end
            end
            R_FETCH: begin
                ram_en_s = 1'b1;
                state_s  = R_DATA;
            end
            R_DATA: begin
                if (axi_s.rready) begin
                    state_s = rlast_r ? IDLE : R_FETCH;
                end else begin
                    state_s = R_DATA;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Burst context, beat counter, error flag, arbitration priority and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_write_r <= 1'b1;
            addr_r       <= {IDX_W{1'b0}};
            len_r        <= 8'd0;
            cnt_r        <= 8'd0;
            fixed_r      <= 1'b0;
            err_r        <= 1'b0;
            wid_r        <= {ID_W_WIDTH{1'b0}};
            rid_r        <= {ID_R_WIDTH{1'b0}};
            bvalid_r     <= 1'b0;
            rvalid_r     <= 1'b0;
            rlast_r      <= 1'b0;
            bresp_r      <= OKAY;
        end else begin
            bvalid_r <= (state_s == W_RESP);
            rvalid_r <= (state_s == R_DATA);
            case (state_r)
                IDLE: begin
                    if (aw_hs_s) begin
                        wid_r        <= axi_s.awid;
                        addr_r       <= axi_s.awaddr[ADDR_WIDTH-1:OFF_W];
                        len_r        <= axi_s.awlen;
                        fixed_r      <= is_fixed(axi_s.awburst);
                        cnt_r        <= 8'd0;
                        err_r        <= 1'b0;
                        prio_write_r <= 1'b0;
                    end else if (ar_hs_s) begin
                        rid_r        <= axi_s.arid;
                        addr_r       <= axi_s.araddr[ADDR_WIDTH-1:OFF_W];
                        len_r        <= axi_s.arlen;
                        fixed_r      <= is_fixed(axi_s.arburst);
                        cnt_r        <= 8'd0;
                        prio_write_r <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (w_hs_s) begin
                        if (wlast_bad_s) begin
                            err_r <= 1'b1;
                        end
                        // Final beat: freeze the response; the burst length, not wlast, ends it.
                        if (last_beat_s) begin
                            bresp_r <= (err_r || wlast_bad_s) ? SLVERR : OKAY;
                        end else begin
                            addr_r <= addr_next_s;
                            cnt_r  <= cnt_r + 8'd1;
                        end
                    end
                end
                W_RESP: begin
                    if (axi_s.bready) begin
                        err_r <= 1'b0;
                    end
                end
                R_FETCH: begin
                    rlast_r <= last_beat_s;
                end
                R_DATA: begin
                    if (axi_s.rready) begin
                        rlast_r <= 1'b0;
                        if (!rlast_r) begin
                            addr_r <= addr_next_s;
                            cnt_r  <= cnt_r + 8'd1;
                        end
                    end
                end
                default: begin
                    err_r <= 1'b0;
                end
            endcase
        end
    end

    sp_ram_be #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .en    (ram_en_s),
        .we    (ram_we_s),
        .be    (axi_s.wstrb),
        .addr  (addr_r),
        .wdata (axi_s.wdata),
        .rdata (ram_rdata_s)
    );

    assign axi_s.awready = awready_s;
    assign axi_s.arready = arready_s;
    assign axi_s.wready  = wready_s;
    assign axi_s.bvalid  = bvalid_r;
    assign axi_s.bid     = wid_r;
    assign axi_s.bresp   = bresp_r;
    assign axi_s.rvalid  = rvalid_r;
    assign axi_s.rid     = rid_r;
    assign axi_s.rdata   = ram_rdata_s;
    assign axi_s.rresp   = OKAY;
    assign axi_s.rlast   = rlast_r;

    // Transfer size is ignored (every beat is full width) and sub-word address bits are dropped.
    assign unused_s = ^{axi_s.awsize, axi_s.arsize, axi_s.awaddr, axi_s.araddr};

endmodule

// File: tb/tb_axi_mesh_mem_slave.sv
// Randomised self-checking bench for axi_mesh_mem_slave against a byte-array memory model.
module tb_axi_mesh_mem_slave;
    localparam int DW  = 8;
    localparam int AW  = 12;
    localparam int IDW = 5;
    localparam int IDR = 5;
    localparam int MEM = 4096;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_W_WIDTH(IDW), .ID_R_WIDTH(IDR)) bus ();

    axi_mesh_mem_slave #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_W_WIDTH(IDW), .ID_R_WIDTH(IDR)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .axi_s (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [7:0] model [MEM];
    logic [7:0] wbuf [256];
    logic       sbuf [256];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int beat_addr(input int base, input int i, input bit fixed);
        return fixed ? base : ((base + i) % MEM);
    endfunction

    task automatic idle_bus();
        bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
        bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
        bus.bready = 1'b0;
        bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0;
        bus.arvalid = 1'b0;
        bus.rready = 1'b0;
    endtask

    task automatic fill_rand(input int len, input bit all_strb);
        for (int i = 0; i <= len; i++) begin
            wbuf[i] = 8'($urandom);
            sbuf[i] = all_strb ? 1'b1 : ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic set_aw(input int id, input int addr, input int len, input logic [1:0] burst);
        bus.awid = 5'(id); bus.awaddr = 12'(addr); bus.awlen = 8'(len);
        bus.awsize = 3'd0; bus.awburst = burst; bus.awvalid = 1'b1;
    endtask

    task automatic set_ar(input int id, input int addr, input int len, input logic [1:0] burst);
        bus.arid = 5'(id); bus.araddr = 12'(addr); bus.arlen = 8'(len);
        bus.arsize = 3'd0; bus.arburst = burst; bus.arvalid = 1'b1;
    endtask

    task automatic do_aw(input int id, input int addr, input int len, input logic [1:0] burst);
        int n;
        bit hs;
        n = 0; hs = 1'b0;
        set_aw(id, addr, len, burst);
        while (!hs && n < 100) begin
            @(negedge clk); hs = bus.awready;
            @(posedge clk); #1; n++;
        end
        bus.awvalid = 1'b0;
        check_eq("aw_handshake", 32'(hs), 32'd1);
    endtask

    task automatic do_ar(input int id, input int addr, input int len, input logic [1:0] burst);
        int n;
        bit hs;
        n = 0; hs = 1'b0;
        set_ar(id, addr, len, burst);
        while (!hs && n < 100) begin
            @(negedge clk); hs = bus.arready;
            @(posedge clk); #1; n++;
        end
        bus.arvalid = 1'b0;
        check_eq("ar_handshake", 32'(hs), 32'd1);
    endtask

    // Sends up to max_beats of a len+1 beat burst; bad_last flips wlast on that beat.
    task automatic do_w(input int len, input int base, input bit fixed, input int bad_last, input int max_beats);
        int n;
        bit hs;
        for (int i = 0; i <= len && i < max_beats; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                bus.wvalid = 1'b0;
                @(posedge clk); #1;
            end
            bus.wdata = wbuf[i]; bus.wstrb = sbuf[i];
            bus.wlast = (i == len) ^ (i == bad_last);
            bus.wvalid = 1'b1;
            n = 0; hs = 1'b0;
            while (!hs && n < 100) begin
                @(negedge clk); hs = bus.wready;
                @(posedge clk); #1; n++;
            end
            if (!hs) check_eq("w_handshake", 32'(hs), 32'd1);
            if (hs && sbuf[i]) model[beat_addr(base, i, fixed)] = wbuf[i];
        end
        bus.wvalid = 1'b0; bus.wlast = 1'b0;
    endtask

    task automatic do_b(input int id, input logic [1:0] resp);
        int n;
        bit seen;
        n = 0; seen = 1'b0;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        bus.bready = 1'b1;
        while (!seen && n < 100) begin
            @(negedge clk); seen = bus.bvalid;
            if (seen) begin
                check_eq("bid", 32'(bus.bid), 32'(id));
                check_eq("bresp", 32'(bus.bresp), 32'(resp));
            end
            @(posedge clk); #1; n++;
        end
        bus.bready = 1'b0;
        check_eq("b_seen", 32'(seen), 32'd1);
    endtask

    // mode 0: rready always high, 1: toggling, 2: random.
    task automatic do_r(input int id, input int base, input int len, input bit fixed,
                        input int mode, input bit chk_lat);
        int i, n;
        bit stalled;
        logic [7:0] held;
        i = 0; n = 0; stalled = 1'b0; held = 8'd0;
        while (i <= len && n < 3000) begin
            case (mode)
                0: bus.rready = 1'b1;
                1: bus.rready = (n % 2 == 0);
                default: bus.rready = 1'($urandom);
            endcase
            @(negedge clk);
            if (chk_lat && n == 0) check_eq("r_latency_valid", 32'(bus.rvalid), 32'd1);
            if (bus.rvalid) begin
                if (stalled) check_eq("r_stable", 32'(bus.rdata), 32'(held));
                if (bus.rready) begin
                    check_eq("rdata", 32'(bus.rdata), 32'(model[beat_addr(base, i, fixed)]));
                    check_eq("rid", 32'(bus.rid), 32'(id));
                    check_eq("rlast", 32'(bus.rlast), 32'(i == len));
                    check_eq("rresp", 32'(bus.rresp), 32'd0);
                    i++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held = bus.rdata;
                end
            end
            @(posedge clk); #1; n++;
        end
        bus.rready = 1'b0;
        check_eq("r_beats", 32'(i), 32'(len + 1));
    endtask

    task automatic write_burst(input int id, input int addr, input int len, input logic [1:0] burst,
                               input int bad_last);
        logic [1:0] exp_resp;
        exp_resp = (bad_last >= 0 && bad_last <= len) ? 2'b10 : 2'b00;
        do_aw(id, addr, len, burst);
        do_w(len, addr, burst == 2'b00, bad_last, 256);
        do_b(id, exp_resp);
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_ready"}, 32'({bus.awready, bus.wready, bus.arready}), 32'd0);
        check_eq({tag, "_valid"}, 32'({bus.bvalid, bus.rvalid, bus.rlast}), 32'd0);
        check_eq({tag, "_resp"}, 32'({bus.bresp, bus.rresp}), 32'd0);
        check_eq({tag, "_data"}, 32'({bus.rdata, bus.bid, bus.rid}), 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int len, addr, bad;
        logic [1:0] burst;
        bit seen;

        idle_bus();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Define every byte of memory so later reads have known expectations (len 255 bursts).
        for (int k = 0; k < 16; k++) begin
            fill_rand(255, 1'b1);
            write_burst(k, k * 256, 255, 2'b01, -1);
        end

        // Single write then read, with read latency check.
        wbuf[0] = 8'hA5; sbuf[0] = 1'b1;
        write_burst(3, 'h010, 0, 2'b01, -1);
        do_ar(7, 'h010, 0, 2'b01);
        @(negedge clk);
        check_eq("r_latency_fetch", 32'(bus.rvalid), 32'd0);
        @(posedge clk); #1;
        do_r(7, 'h010, 0, 1'b0, 0, 1'b1);
        check_eq("single_model", 32'(model['h010]), 32'hA5);

        // 4-beat INCR write/read with toggling rready.
        wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33; wbuf[3] = 8'h44;
        for (int i = 0; i < 4; i++) sbuf[i] = 1'b1;
        write_burst(1, 'h020, 3, 2'b01, -1);
        do_ar(2, 'h020, 3, 2'b01);
        do_r(2, 'h020, 3, 1'b0, 1, 1'b0);

        // Contention: write, then read, then write.
        fill_rand(1, 1'b1);
        set_aw(4, 'h100, 1, 2'b01);
        set_ar(5, 'h100, 1, 2'b01);
        @(negedge clk);
        check_eq("arb1_grant", 32'({bus.awready, bus.arready}), 32'b10);
        @(posedge clk); #1;
        bus.awvalid = 1'b0;
        do_w(1, 'h100, 1'b0, -1, 256);
        do_b(4, 2'b00);
        set_aw(6, 'h200, 0, 2'b01);
        @(negedge clk);
        check_eq("arb2_grant", 32'({bus.awready, bus.arready}), 32'b01);
        @(posedge clk); #1;
        bus.arvalid = 1'b0;
        do_r(5, 'h100, 1, 1'b0, 0, 1'b0);
        set_ar(5, 'h100, 1, 2'b01);
        @(negedge clk);
        check_eq("arb3_grant", 32'({bus.awready, bus.arready}), 32'b10);
        @(posedge clk); #1;
        bus.awvalid = 1'b0;
        fill_rand(0, 1'b1);
        do_w(0, 'h200, 1'b0, -1, 256);
        do_b(6, 2'b00);
        do_ar(5, 'h100, 1, 2'b01);
        do_r(5, 'h100, 1, 1'b0, 0, 1'b0);

        // Early wlast: all three beats written, SLVERR returned.
        fill_rand(2, 1'b1);
        write_burst(8, 'h300, 2, 2'b01, 1);
        do_ar(9, 'h300, 2, 2'b01);
        do_r(9, 'h300, 2, 1'b0, 0, 1'b0);

        // Address wrap at the top of memory.
        fill_rand(1, 1'b1);
        write_burst(9, 'hFFF, 1, 2'b01, -1);
        do_ar(10, 'hFFF, 1, 2'b01);
        do_r(10, 'hFFF, 1, 1'b0, 0, 1'b0);

        // Reset during beat 2 of a len 3 write.
        fill_rand(3, 1'b1);
        do_aw(11, 'h400, 3, 2'b01);
        do_w(3, 'h400, 1'b0, -1, 1);
        bus.wdata = wbuf[1]; bus.wstrb = 1'b1; bus.wvalid = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        check_outputs_zero("midrst");
        bus.wvalid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 1'b0;
        repeat (10) begin @(negedge clk); seen = seen | bus.bvalid; end
        check_eq("midrst_no_b", 32'(seen), 32'd0);
        @(posedge clk); #1;
        fill_rand(0, 1'b1);
        write_burst(12, 'h500, 0, 2'b01, -1);
        do_ar(13, 'h400, 3, 2'b01);
        do_r(13, 'h400, 3, 1'b0, 2, 1'b0);

        // Randomised mix of bursts, burst types, strobes and wlast errors.
        for (int t = 0; t < 40; t++) begin
            len   = $urandom_range(0, 15);
            addr  = $urandom_range(0, MEM - 1);
            burst = 2'($urandom_range(0, 2));
            if ($urandom_range(0, 1) == 0) begin
                bad = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len)) : -1;
                fill_rand(len, 1'b0);
                write_burst($urandom_range(0, 31), addr, len, burst, bad);
            end else begin
                do_ar(t % 32, addr, len, burst);
                do_r(t % 32, addr, len, burst == 2'b00, 2, 1'b0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
